// File: rtl/proc_control_fsm_if.sv
// Handshake/control bundle between the instruction source and the multicycle control FSM.
// The master drives run/din; the slave (control FSM) drives the datapath strobes.
interface proc_control_fsm_if #(
    parameter int unsigned DATA_W = 16
) ();
    logic              run;
    logic [DATA_W-1:0] din;
    logic              ir_in;
    logic [7:0]        r_in;
    logic              a_in;
    logic              g_in;
    logic              addsub;
    logic [3:0]        bus_sel;
    logic              done;

    modport master (
        output run, din,
        input  ir_in, r_in, a_in, g_in, addsub, bus_sel, done
    );

    modport slave (
        input  run, din,
        output ir_in, r_in, a_in, g_in, addsub, bus_sel, done
    );
endinterface

// File: rtl/proc_control_fsm.sv
// Multicycle control unit: fetches an instruction from din on run and sequences
// register/A/G write enables, bus source select, ALU op and a done pulse.
module proc_control_fsm #(
    parameter int unsigned DATA_W = 16
) (
    input logic              clock,
    input logic              resetn,
    proc_control_fsm_if.slave bus
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StT1   = 2'd1;
    localparam logic [1:0] StT2   = 2'd2;
    localparam logic [1:0] StT3   = 2'd3;

    localparam logic [3:0] OpMv  = 4'b0000;
    localparam logic [3:0] OpMvi = 4'b0001;
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpSub = 4'b0011;

    localparam logic [3:0] SelG    = 4'd8;
    localparam logic [3:0] SelDin  = 4'd9;
    localparam logic [3:0] SelNone = 4'd15;

    logic [1:0] state_q, state_d;
    // Only ir[15:6] is ever decoded, so only those bits are kept.
    logic [9:0] ir_q, ir_d;
    logic [3:0] op;
    logic [2:0] rx, ry;
    logic       unused_din;

    assign op         = ir_q[9:6];
    assign rx         = ir_q[5:3];
    assign ry         = ir_q[2:0];
    assign unused_din = ^bus.din;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        unique case (state_q)
            StIdle: begin
                if (bus.run) begin
                    ir_d    = bus.din[15:6];
                    state_d = StT1;
                end
            end
            StT1: begin
                if (op == OpAdd || op == OpSub) begin
                    state_d = StT2;
                end else begin
                    state_d = StIdle;
                end
            end
            StT2: state_d = StT3;
            StT3: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        // resetn gates the one input-dependent strobe so reset forces every enable low.
        bus.ir_in   = (state_q == StIdle) && bus.run && resetn;
        bus.r_in    = 8'h00;
        bus.a_in    = 1'b0;
        bus.g_in    = 1'b0;
        bus.addsub  = 1'b0;
        bus.bus_sel = SelNone;
        bus.done    = 1'b0;
        unique case (state_q)
            StIdle: ;
            StT1: begin
                unique case (op)
                    OpMv: begin
                        bus.bus_sel = {1'b0, ry};
                        bus.r_in    = 8'h01 << rx;
                        bus.done    = 1'b1;
                    end
                    OpMvi: begin
                        bus.bus_sel = SelDin;
                        bus.r_in    = 8'h01 << rx;
                        bus.done    = 1'b1;
                    end
                    OpAdd, OpSub: begin
                        bus.bus_sel = {1'b0, rx};
                        bus.a_in    = 1'b1;
                    end
                    default: bus.done = 1'b1;
                endcase
            end
            StT2: begin
                bus.bus_sel = {1'b0, ry};
                bus.g_in    = 1'b1;
                bus.addsub  = op[0];
            end
            StT3: begin
                bus.bus_sel = SelG;
                bus.r_in    = 8'h01 << rx;
                bus.done    = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_proc_control_fsm.sv
// Directed, table-driven bench for proc_control_fsm plus hand-written reset and
// back-to-back sequences.
module tb_proc_control_fsm;
    typedef struct packed {
        logic       ir_in;
        logic [7:0] r_in;
        logic       a_in;
        logic       g_in;
        logic       addsub;
        logic [3:0] bus_sel;
        logic       done;
    } outs_t;

    typedef struct {
        logic        run;
        logic [15:0] din;
        outs_t       exp;
    } vec_t;

    logic clock = 1'b0;
    logic resetn;
    int   n_checks = 0;
    int   n_pass   = 0;

    proc_control_fsm_if #(.DATA_W(16)) bus ();

    proc_control_fsm #(.DATA_W(16)) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic outs_t mk(logic ir, logic [7:0] r, logic a, logic g, logic as,
                                 logic [3:0] bs, logic d);
        outs_t o;
        o.ir_in   = ir;
        o.r_in    = r;
        o.a_in    = a;
        o.g_in    = g;
        o.addsub  = as;
        o.bus_sel = bs;
        o.done    = d;
        return o;
    endfunction

    task automatic check(input string name, input outs_t exp);
        outs_t act;
        act = mk(bus.ir_in, bus.r_in, bus.a_in, bus.g_in, bus.addsub, bus.bus_sel, bus.done);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got ir_in=%b r_in=%h a_in=%b g_in=%b addsub=%b bus_sel=%0d done=%b; want ir_in=%b r_in=%h a_in=%b g_in=%b addsub=%b bus_sel=%0d done=%b",
                     name, act.ir_in, act.r_in, act.a_in, act.g_in, act.addsub, act.bus_sel,
                     act.done, exp.ir_in, exp.r_in, exp.a_in, exp.g_in, exp.addsub,
                     exp.bus_sel, exp.done);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, then sample before the rising edge.
    task automatic step(input string name, input logic run, input logic [15:0] din,
                        input outs_t exp);
        @(negedge clock);
        bus.run = run;
        bus.din = din;
        #1;
        check(name, exp);
    endtask

    vec_t  vecs[$];
    outs_t idle;

    initial begin
        idle = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd15, 1'b0);

        // MVI R0, #5
        vecs.push_back('{1'b1, 16'h1000, mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4'd15, 1'b0)});
        vecs.push_back('{1'b0, 16'h0005, mk(1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 4'd9,  1'b1)});
        vecs.push_back('{1'b0, 16'h0000, idle});
        // MV R1, R0
        vecs.push_back('{1'b1, 16'h0200, mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4'd15, 1'b0)});
        vecs.push_back('{1'b0, 16'h0000, mk(1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1)});
        // ADD R0, R1
        vecs.push_back('{1'b1, 16'h2040, mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4'd15, 1'b0)});
        vecs.push_back('{1'b0, 16'h0000, mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0)});
        vecs.push_back('{1'b0, 16'h0000, mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd1,  1'b0)});
        vecs.push_back('{1'b0, 16'h0000, mk(1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 4'd8,  1'b1)});
        // SUB R7, R1 with run held high; din changes must be ignored while busy
        vecs.push_back('{1'b1, 16'h3E40, mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4'd15, 1'b0)});
        vecs.push_back('{1'b1, 16'h1000, mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd7,  1'b0)});
        vecs.push_back('{1'b1, 16'h1000, mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 4'd1,  1'b0)});
        vecs.push_back('{1'b1, 16'h1000, mk(1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 4'd8,  1'b1)});
        // Next fetch (illegal F000) exactly one cycle after done
        vecs.push_back('{1'b1, 16'hF000, mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4'd15, 1'b0)});
        vecs.push_back('{1'b0, 16'h0000, mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd15, 1'b1)});
        vecs.push_back('{1'b0, 16'h0000, idle});
        // ADD R3, R3
        vecs.push_back('{1'b1, 16'h26C0, mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4'd15, 1'b0)});
        vecs.push_back('{1'b0, 16'h0000, mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd3,  1'b0)});
        vecs.push_back('{1'b0, 16'h0000, mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd3,  1'b0)});
        vecs.push_back('{1'b0, 16'h0000, mk(1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 4'd8,  1'b1)});
        vecs.push_back('{1'b0, 16'h0000, idle});

        resetn  = 1'b0;
        bus.run = 1'b1;
        bus.din = 16'h1000;
        @(negedge clock);
        #1;
        check("reset_state_run_high", idle);
        @(negedge clock);
        bus.run = 1'b0;
        resetn  = 1'b1;
        #1;
        check("after_release", idle);

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].run, vecs[i].din, vecs[i].exp);
        end

        // Async reset in T2 of ADD R0, R1, with run asserted to test ir_in gating
        step("rst_fetch", 1'b1, 16'h2040, mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4'd15, 1'b0));
        step("rst_t1", 1'b0, 16'h0000, mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0));
        step("rst_t2", 1'b0, 16'h0000, mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0));
        bus.run = 1'b1;
        #1;
        resetn = 1'b0;
        #1;
        check("async_reset_now", idle);
        @(negedge clock);
        #1;
        check("reset_held", idle);
        @(negedge clock);
        bus.run = 1'b0;
        resetn  = 1'b1;
        #1;
        check("reset_release", idle);
        for (int k = 0; k < 2; k++) begin
            step($sformatf("no_write_after_reset%0d", k), 1'b0, 16'h0000, idle);
        end
        step("post_reset_fetch", 1'b1, 16'h0200, mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4'd15, 1'b0));
        step("post_reset_mv", 1'b0, 16'h0000, mk(1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1));
        step("post_reset_idle", 1'b0, 16'h0000, idle);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
